snowv_stream_cipher: RTL and testbench

Data-path front end for the SNOW-V keystream generator. It accepts a key/IV/length command, starts the generator, and buffers the generator's non-stallable 128-bit keystream in a small FIFO. It then XORs each keystream word with incoming 128-bit data blocks under valid/ready handshakes. The same block serves encryption and decryption; it sits between the bus-side stream and the generator.

---
 rtl/snowv_pkg.sv | 18 +
 rtl/snowv_ks_fifo.sv | 54 +++++
 rtl/snowv_stream_cipher.sv | 147 ++++++++++++++
 tb/tb_snowv_stream_cipher.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snowv_pkg.sv
// Shared definitions for the SNOW-V keystream front end.
// Field widths for key, IV, data block and block count, and the
// state encoding of the command/transfer FSM.
package snowv_pkg;

  localparam int KEY_W = 256;
  localparam int IV_W  = 128;
  localparam int BLK_W = 128;
  localparam int LEN_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } snowv_state_e;

endpackage

// File: rtl/snowv_ks_fifo.sv
// Keystream buffer: synchronous FIFO of BLK_W-bit words, FIFO_DEPTH deep.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   clr        - synchronous flush, used when a new command is accepted
//   push/wdata - write request and word; honoured when not full, or when
//                full and a pop happens in the same cycle
//   pop/rdata  - read request and current head word (no write bypass)
//   full/empty - occupancy flags
module snowv_ks_fifo
  import snowv_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [BLK_W-1:0] wdata,
  input  logic             pop,
  output logic [BLK_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [BLK_W-1:0] mem [FIFO_DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/snowv_stream_cipher.sv
// SNOW-V data-path front end.
// Accepts a key/IV/length command, pulses the generator start, buffers the
// generator's non-stallable keystream and XORs it onto the data stream.
// Ports:
//   cmd_*      - command handshake (key, IV, block count); ready only in IDLE
//   gen_*      - generator control (start pulse, registered key/IV/length)
//                and keystream input (gen_valid/gen_z, no backpressure)
//   din_*      - input block stream, valid/ready
//   dout_*     - output block stream, valid/ready, last marks block len-1
//   busy       - FSM not in IDLE
//   overflow   - sticky, a keystream word was dropped on a full FIFO
module snowv_stream_cipher
  import snowv_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [KEY_W-1:0] cmd_key,
  input  logic [IV_W-1:0]  cmd_iv,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             gen_start,
  output logic [KEY_W-1:0] gen_key,
  output logic [IV_W-1:0]  gen_iv,
  output logic [LEN_W-1:0] gen_length,
  input  logic             gen_valid,
  input  logic [BLK_W-1:0] gen_z,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [BLK_W-1:0] din_data,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [BLK_W-1:0] dout_data,
  output logic             dout_last,
  output logic             busy,
  output logic             overflow
);

  snowv_state_e     state;
  snowv_state_e     state_nxt;

  logic [KEY_W-1:0] key_reg;
  logic [IV_W-1:0]  iv_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] in_cnt;
  logic             ovf_reg;

  logic             cmd_fire;
  logic             din_fire;
  logic             dout_fire;
  logic             last_blk;
  logic             ks_push;
  logic             ks_full;
  logic             ks_empty;
  logic [BLK_W-1:0] ks_head;

  logic [BLK_W-1:0] data_p1;
  logic             vld_p1;
  logic             last_p1;

  assign cmd_fire  = (state == IDLE) && cmd_valid;
  assign din_ready = (state == RUN) && !ks_empty && (in_cnt < len_reg) && (!vld_p1 || dout_ready);
  assign din_fire  = din_valid && din_ready;
  assign dout_fire = vld_p1 && dout_ready;
  assign last_blk  = (in_cnt == len_reg - LEN_W'(1));
  assign ks_push   = (state == RUN) && gen_valid;

  snowv_ks_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ks_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (cmd_fire),
    .push  (ks_push),
    .wdata (gen_z),
    .pop   (din_fire),
    .rdata (ks_head),
    .full  (ks_full),
    .empty (ks_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire && (cmd_len != '0)) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (din_fire && last_blk) state_nxt = DRAIN;
      DRAIN:   if (dout_fire && last_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_reg <= '0;
      iv_reg  <= '0;
      len_reg <= '0;
      in_cnt  <= '0;
      ovf_reg <= 1'b0;
    end else if (cmd_fire) begin
      key_reg <= cmd_key;
      iv_reg  <= cmd_iv;
      len_reg <= cmd_len;
      in_cnt  <= '0;
      ovf_reg <= 1'b0;
    end else begin
      if (din_fire) in_cnt <= in_cnt + LEN_W'(1);
      // A word arriving on a full FIFO survives only if the head leaves this cycle.
      if (ks_push && ks_full && !din_fire) ovf_reg <= 1'b1;
    end
  end

  // Stage p1: XOR of accepted block with keystream head, held until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (din_fire) begin
      data_p1 <= din_data ^ ks_head;
      vld_p1  <= 1'b1;
      last_p1 <= last_blk;
    end else if (dout_fire) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign gen_start  = (state == START);
  assign gen_key    = key_reg;
  assign gen_iv     = iv_reg;
  assign gen_length = len_reg;
  assign dout_valid = vld_p1;
  assign dout_data  = data_p1;
  assign dout_last  = last_p1;
  assign overflow   = ovf_reg;

endmodule

// File: tb/tb_snowv_stream_cipher.sv
// Bench for snowv_stream_cipher. A behavioural generator stand-in produces a
// keystream that is a pure function of (key, IV, word index); a scoreboard
// predicts each output block from the accepted input block and that function.
module tb_snowv_stream_cipher;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] cmd_key;
  logic [127:0] cmd_iv;
  logic [63:0]  cmd_len;
  logic         gen_start;
  logic [255:0] gen_key;
  logic [127:0] gen_iv;
  logic [63:0]  gen_length;
  logic         gen_valid;
  logic [127:0] gen_z;
  logic         din_valid;
  logic         din_ready;
  logic [127:0] din_data;
  logic         dout_valid;
  logic         dout_ready;
  logic [127:0] dout_data;
  logic         dout_last;
  logic         busy;
  logic         overflow;

  snowv_stream_cipher #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_key(cmd_key), .cmd_iv(cmd_iv), .cmd_len(cmd_len),
    .gen_start(gen_start), .gen_key(gen_key), .gen_iv(gen_iv), .gen_length(gen_length),
    .gen_valid(gen_valid), .gen_z(gen_z),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic         l;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t         sb_q[$];
  logic [127:0] got_q[$];
  logic [127:0] tx_q[$];
  logic [127:0] pt_q[$];
  logic [127:0] ct_q[$];

  logic [255:0]    m_key;
  logic [127:0]    m_iv;
  longint unsigned m_len;
  longint unsigned m_idx;
  bit              sb_skip  = 0;
  bit              rdy_rand = 0;
  bit              idle_chk = 0;
  int              out_cnt  = 0;

  logic [255:0]    g_key;
  logic [127:0]    g_iv;
  longint unsigned g_left = 0;
  int              g_wait = 0;
  int              g_idx  = 0;
  int              g_more = 0;
  int              gen_emitted = 0;

  task automatic chkw(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  task automatic chkb(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", nm, got, exp);
  endtask

  // Stand-in keystream: deterministic in (key, iv, index), distinct per index.
  function automatic logic [127:0] ks_word(input logic [255:0] k, input logic [127:0] v, input int unsigned i);
    logic [31:0] m;
    m = (i + 32'd1) * 32'h9E3779B9;
    return k[255:128] ^ k[127:0] ^ {v[63:0], v[127:64]} ^ {m, ~m, m ^ 32'h5A5A5A5A, m + 32'h01234567};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Generator model: first word 17 cycles after the start pulse, then one per cycle.
  always @(posedge clk) begin : gen_model
    logic r;
    r = rst;
    #1;
    gen_valid = 1'b0;
    if (r) begin
      g_left = 0; g_wait = 0; g_more = 0;
    end else if (gen_start) begin
      g_key = gen_key; g_iv = gen_iv; g_left = gen_length;
      g_wait = 17; g_idx = 0; g_more = 0; gen_emitted = 0;
    end else begin
      if (g_wait > 0) g_wait--;
      if (g_wait == 0 && (g_left > 0 || g_more > 0)) begin
        gen_valid = 1'b1;
        gen_z = ks_word(g_key, g_iv, g_idx);
        g_idx++;
        gen_emitted++;
        if (g_left > 0) g_left--;
        else g_more--;
      end
    end
  end

  always @(posedge clk) begin : rdy_gen
    #1;
    if (rdy_rand) dout_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin : mon_in
    if (!rst && din_valid && din_ready && !sb_skip) begin
      sb_q.push_back({din_data ^ ks_word(m_key, m_iv, 32'(m_idx)), (m_idx == m_len - 1)});
      m_idx++;
    end
  end

  always @(negedge clk) begin : mon_out
    exp_t e;
    if (idle_chk) begin
      chkb("cmd_ready_after_last", cmd_ready, 1'b1);
      chkb("busy_after_last", busy, 1'b0);
      idle_chk = 0;
    end
    if (!rst && dout_valid && dout_ready) begin
      out_cnt++;
      got_q.push_back(dout_data);
      if (!sb_skip) begin
        if (sb_q.size() == 0) begin
          chkb("unexpected_dout", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chkw("dout_data", 256'(dout_data), 256'(e.d));
          chkb("dout_last", dout_last, e.l);
        end
      end
      if (dout_last) idle_chk = 1;
    end
  end

  task automatic send_cmd(input logic [255:0] k, input logic [127:0] v, input logic [63:0] n);
    @(posedge clk); #1;
    chkb("cmd_ready_idle", cmd_ready, 1'b1);
    m_key = k; m_iv = v; m_len = n; m_idx = 0;
    got_q.delete();
    out_cnt = 0;
    cmd_valid = 1'b1; cmd_key = k; cmd_iv = v; cmd_len = n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chkb("gen_start_pulse", gen_start, n != 0);
    chkb("busy_after_cmd", busy, n != 0);
    chkb("overflow_cleared", overflow, 1'b0);
    if (n != 0) begin
      chkw("gen_key", gen_key, k);
      chkw("gen_iv", 256'(gen_iv), 256'(v));
      chkw("gen_length", 256'(gen_length), 256'(n));
      @(posedge clk); #1;
      chkb("gen_start_once", gen_start, 1'b0);
    end
  endtask

  task automatic drive_blocks(input int n, input bit rnd);
    bit fired;
    int guard;
    for (int i = 0; i < n; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      din_valid = 1'b1;
      din_data  = tx_q[i];
      fired = 0;
      guard = 0;
      while (!fired && guard < 400) begin
        @(negedge clk);
        fired = din_ready;
        @(posedge clk); #1;
        guard++;
      end
      din_valid = 1'b0;
      if (!fired) begin
        chkb("din_accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chkb("transfer_done", ok, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic fill_tx(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back(rnd128());
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [255:0] k;
    logic [127:0] v;
    logic [127:0] hold;
    logic         hold_last;
    bit           ok;
    logic         bad;
    int           n;

    rst = 1'b1; cmd_valid = 1'b0; cmd_key = '0; cmd_iv = '0; cmd_len = '0;
    din_valid = 1'b0; din_data = '0; dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_cmd_ready", cmd_ready, 1'b1);
    chkb("rst_gen_start", gen_start, 1'b0);
    chkw("rst_gen_key", gen_key, 256'(0));
    chkw("rst_gen_iv", 256'(gen_iv), 256'(0));
    chkw("rst_gen_length", 256'(gen_length), 256'(0));
    chkb("rst_din_ready", din_ready, 1'b0);
    chkb("rst_dout_valid", dout_valid, 1'b0);
    chkw("rst_dout_data", 256'(dout_data), 256'(0));
    chkb("rst_dout_last", dout_last, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_overflow", overflow, 1'b0);
    rst = 1'b0;

    // All-zero key/IV, zero data: outputs are the raw keystream.
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(128'd0);
    send_cmd(256'd0, 128'd0, 64'd4);
    drive_blocks(4, 0);
    wait_done(200);
    chkw("zero_out_count", 256'(got_q.size()), 256'(4));
    for (int i = 0; i < got_q.size(); i++)
      chkw("zero_keystream", 256'(got_q[i]), 256'(ks_word(256'd0, 128'd0, i)));

    // Round trip: encrypt, then decrypt with the same key/IV.
    k = {rnd128(), rnd128()};
    v = rnd128();
    pt_q = '{128'd1, 128'd2, 128'd3};
    tx_q = pt_q;
    send_cmd(k, v, 64'd3);
    drive_blocks(3, 0);
    wait_done(200);
    ct_q = got_q;
    chkw("rt_ct_count", 256'(ct_q.size()), 256'(3));
    tx_q = ct_q;
    send_cmd(k, v, 64'd3);
    drive_blocks(3, 0);
    wait_done(200);
    chkw("rt_pt_count", 256'(got_q.size()), 256'(3));
    for (int i = 0; i < got_q.size() && i < 3; i++)
      chkw("rt_plaintext", 256'(got_q[i]), 256'(pt_q[i]));

    // Backpressure: hold dout_ready low three cycles after the first output.
    k = {rnd128(), rnd128()};
    v = rnd128();
    fill_tx(4);
    send_cmd(k, v, 64'd4);
    fork
      drive_blocks(4, 0);
      begin
        ok = 0;
        for (int i = 0; i < 200; i++) begin
          @(posedge clk); #1;
          if (out_cnt >= 1) begin ok = 1; break; end
        end
        chkb("stall_first_out", ok, 1'b1);
        dout_ready = 1'b0;
        hold = dout_data;
        hold_last = dout_last;
        repeat (3) begin
          @(negedge clk);
          chkb("stall_valid", dout_valid, 1'b1);
          chkb("stall_din_ready", din_ready, 1'b0);
          chkw("stall_data", 256'(dout_data), 256'(hold));
          chkb("stall_last", dout_last, hold_last);
        end
        @(posedge clk); #1;
        dout_ready = 1'b1;
      end
    join
    wait_done(200);
    chkw("stall_out_count", 256'(got_q.size()), 256'(4));
    chkb("stall_no_overflow", overflow, 1'b0);

    // Randomised transfers with input gaps and random downstream stalls.
    rdy_rand = 1;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 8);
      k = {rnd128(), rnd128()};
      v = rnd128();
      fill_tx(n);
      send_cmd(k, v, 64'(n));
      drive_blocks(n, 1);
      wait_done(400);
    end
    rdy_rand = 0;
    #1;
    dout_ready = 1'b1;

    // Overflow: 12 words with no input consumption.
    k = {rnd128(), rnd128()};
    v = rnd128();
    fill_tx(12);
    sb_skip = 1;
    send_cmd(k, v, 64'd12);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gen_emitted == 9) begin ok = 1; break; end
    end
    chkb("ovf_ninth_word", ok, 1'b1);
    chkb("ovf_before_ninth", overflow, 1'b0);
    @(negedge clk);
    chkb("ovf_after_ninth", overflow, 1'b1);
    g_more = 12;
    @(posedge clk); #1;
    drive_blocks(12, 0);
    wait_done(400);
    chkb("ovf_sticky", overflow, 1'b1);
    sb_skip = 0;
    k = {rnd128(), rnd128()};
    v = rnd128();
    fill_tx(2);
    send_cmd(k, v, 64'd2);
    drive_blocks(2, 0);
    wait_done(200);

    // Zero-length command completes silently.
    send_cmd({rnd128(), rnd128()}, rnd128(), 64'd0);
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      bad = bad | gen_start | dout_valid | busy | !cmd_ready;
    end
    chkb("len0_quiet", bad, 1'b0);
    @(posedge clk); #1;

    // Reset in the middle of a len=6 transfer.
    k = {rnd128(), rnd128()};
    v = rnd128();
    send_cmd(k, v, 64'd6);
    din_valid = 1'b1;
    din_data  = rnd128();
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_cnt >= 2) begin ok = 1; break; end
    end
    chkb("rst_mid_two_outs", ok, 1'b1);
    rst = 1'b1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    chkb("rstmid_dout_valid", dout_valid, 1'b0);
    chkb("rstmid_busy", busy, 1'b0);
    chkb("rstmid_overflow", overflow, 1'b0);
    chkb("rstmid_din_ready", din_ready, 1'b0);
    chkb("rstmid_cmd_ready", cmd_ready, 1'b1);
    chkw("rstmid_dout_data", 256'(dout_data), 256'(0));
    k = {rnd128(), rnd128()};
    v = rnd128();
    fill_tx(2);
    send_cmd(k, v, 64'd2);
    drive_blocks(2, 0);
    wait_done(200);
    chkw("rstmid_out_count", 256'(got_q.size()), 256'(2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
